// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if: register bus between a host and the seven-segment scan controller.
interface seg_display_ctrl_if;
    logic        bus_wen;
    logic        bus_ren;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    modport master (output bus_wen, bus_ren, bus_addr, bus_wdata, input bus_rdata, bus_ready);
    modport slave  (input bus_wen, bus_ren, bus_addr, bus_wdata, output bus_rdata, bus_ready);
endinterface

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: six-digit multiplexed seven-segment driver with blanking dead time and a small register bus.
module seg_display_ctrl #(
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                nrst,
    seg_display_ctrl_if.slave   bus,
    output logic [7:0]          segment,
    output logic [5:0]          sel
);
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
    localparam logic [19:0] SHOW_END  = 20'(SCAN_DIV - 1);
    localparam logic [19:0] BLANK_END = 20'(BLANK_CYCLES - 1);
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    state_t      r_state, w_state_n;
    logic [2:0]  r_idx, w_idx_n;
    logic [19:0] r_cnt, w_cnt_n;
    logic [23:0] r_data;
    logic [5:0]  r_dp, r_mask;
    logic        r_en, r_ready;
    logic [31:0] r_rdata, w_rd, w_status;
    logic [3:0]  w_nib;
    logic [5:0]  w_sel_n;
    logic [7:0]  w_seg_n;
    logic        w_unused;
    assign w_unused = ^bus.bus_wdata[31:24];
    assign w_status = {27'd0, r_state == BLANK, 1'b0, r_idx};
    assign w_rd = bus.bus_addr == 2'd0 ? {8'd0, r_data} :
                  bus.bus_addr == 2'd1 ? {26'd0, r_dp} :
                  bus.bus_addr == 2'd2 ? {18'd0, r_mask, 7'd0, r_en} : w_status;
    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_cnt_n   = r_cnt + 20'd1;
        if (!r_en) begin
            w_state_n = IDLE;
            w_idx_n   = 3'd0;
            w_cnt_n   = 20'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_n = SHOW;
                    w_idx_n   = 3'd0;
                    w_cnt_n   = 20'd0;
                end
                SHOW: if (r_cnt == SHOW_END) begin
                    w_state_n = BLANK;
                    w_cnt_n   = 20'd0;
                end
                BLANK: if (r_cnt == BLANK_END) begin
                    w_state_n = SHOW;
                    w_idx_n   = r_idx == 3'd5 ? 3'd0 : r_idx + 3'd1;
                    w_cnt_n   = 20'd0;
                end
                default: begin
                    w_state_n = IDLE;
                    w_idx_n   = 3'd0;
                    w_cnt_n   = 20'd0;
                end
            endcase
        end
    end
    // Outputs are loaded from the next state so they switch on the same edge as the FSM.
    assign w_nib   = r_data[{w_idx_n, 2'b00} +: 4];
    assign w_sel_n = w_state_n == SHOW ? ~(6'd1 << w_idx_n) : 6'h3F;
    assign w_seg_n = (w_state_n == SHOW && !r_mask[w_idx_n]) ? {~r_dp[w_idx_n], HEX[w_nib]} : 8'hFF;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 20'd0;
            sel     <= 6'h3F;
            segment <= 8'hFF;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
            r_cnt   <= w_cnt_n;
            sel     <= w_sel_n;
            segment <= w_seg_n;
        end
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_data  <= 24'd0;
            r_dp    <= 6'd0;
            r_mask  <= 6'd0;
            r_en    <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= bus.bus_wen | bus.bus_ren;
            r_rdata <= (bus.bus_ren && !bus.bus_wen) ? w_rd : 32'd0;
            if (bus.bus_wen && bus.bus_addr == 2'd0) r_data <= bus.bus_wdata[23:0];
            if (bus.bus_wen && bus.bus_addr == 2'd1) r_dp <= bus.bus_wdata[5:0];
            if (bus.bus_wen && bus.bus_addr == 2'd2) begin
                r_en   <= bus.bus_wdata[0];
                r_mask <= bus.bus_wdata[13:8];
            end
        end
    end
    assign bus.bus_ready = r_ready;
    assign bus.bus_rdata = r_rdata;
endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, clk cycles a digit is lit (SHOW phase); legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, all-off dead-time cycles between digits; legal range 1..SCAN_DIV-1.
REQ-003 SHALL have port clk  input  1  system clock; reset nrst, asynchronous, active-low.
REQ-004 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports bus_wen  input  1  write request; bus_ren  input  1  read request.
REQ-006 SHALL have ports bus_addr  input  2  word address; bus_wdata  input  32  write data.
REQ-007 SHALL have ports bus_rdata  output  32  read data; bus_ready  output  1  completion pulse.
REQ-008 SHALL have ports segment  output  8  active-low segments, bit7=dp, bits6:0=g..a; sel  output  6  active-low one-hot digit select, bit0 = rightmost digit.

Function
REQ-009 SHALL implement registers: addr0 DATA[23:0] (nibble i = digit i); addr1 DP[5:0]; addr2 CTRL: bit0 EN, bits13:8 BLANK mask; addr3 STATUS read-only: bits2:0 current digit index, bit4 = 1 in BLANK state.
REQ-010 SHALL update the addressed register on the clk edge where bus_wen=1; bits outside defined fields are ignored; writes to addr3 are dropped.
REQ-011 SHALL, for a request (bus_wen or bus_ren) in cycle N, assert bus_ready for exactly cycle N+1; a request held high is a new request every cycle.
REQ-012 SHALL return read data in cycle N+1 with bus_ready, undefined bits zero; bus_rdata SHALL be 0 whenever bus_ready=0.
REQ-013 SHALL, on simultaneous bus_wen and bus_ren, perform the write only; bus_rdata=0 in the ready cycle.
REQ-014 SHALL implement FSM IDLE/SHOW/BLANK with a digit index 0..5 and a phase counter.
REQ-015 IDLE: entered whenever EN=0; index=0, counter=0, sel=6'h3F, segment=8'hFF.
REQ-016 IDLE->SHOW on the edge after EN becomes 1, index 0, counter 0.
REQ-017 SHOW lasts exactly SCAN_DIV cycles, then BLANK for exactly BLANK_CYCLES, then SHOW with index+1, wrapping 5->0.
REQ-018 SHALL, in SHOW, drive sel = ~(1<<index) and segment = {~DP[index], decode(DATA[4*index+3:4*index])}; in BLANK, sel=6'h3F, segment=8'hFF.
REQ-019 SHALL drive segment 8'hFF during SHOW of digit i when BLANK mask bit i=1; sel still driven.
REQ-020 SHALL decode hex active-low (bit0=a): 0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 4->7'h19, 5->7'h12, 6->7'h02, 7->7'h78, 8->7'h00, 9->7'h10, A->7'h08, b->7'h03, C->7'h46, d->7'h21, E->7'h06, F->7'h0E.
REQ-021 SHALL register sel and segment; they change on the same edge the FSM changes state; a DATA/DP/mask write during SHOW is visible on segment one cycle after the write edge.
REQ-022 SHALL never assert more than one sel bit low; sel SHALL be 6'h3F for at least BLANK_CYCLES between any two different lit digits.
REQ-023 SHALL, on EN cleared mid-SHOW or mid-BLANK, enter IDLE on the next edge (outputs blank, index 0); no partial-phase carry-over on re-enable.

Reset
REQ-024 SHALL, on nrst=0, asynchronously clear DATA, DP, CTRL, index, counter to 0, state IDLE, sel=6'h3F, segment=8'hFF, bus_ready=0, bus_rdata=0.
REQ-025 SHALL resume normal operation on the first clk edge after nrst deasserts; bus requests during reset are lost.

Verification (SCAN_DIV=4, BLANK_CYCLES=2)
REQ-026 Reset then idle 10 cycles -> sel=6'h3F, segment=8'hFF, bus_ready=0 throughout.
REQ-027 Write DATA=24'h012345, DP=6'h01, CTRL=1 -> digit0 SHOW 4 cycles sel=6'h3E segment=8'h12; 2 cycles 6'h3F/8'hFF; digit1 sel=6'h3D segment=8'h99; after digit5 (segment=8'hC0) wraps to digit0.
REQ-028 Read addr0 after writing 32'hFFAB_CDEF -> bus_ready one cycle later, bus_rdata=32'h00AB_CDEF; read addr3 during BLANK after digit2 -> 32'h12.
REQ-029 Simultaneous wen/ren to addr1 data 6'h3F -> DP updated, bus_rdata=0 with bus_ready; write addr3 -> STATUS unchanged, ready pulse given.
REQ-030 CTRL=32'h0000_0401 -> digit2 SHOW shows sel=6'h3B, segment=8'hFF; clear EN mid-digit3 -> next cycle IDLE outputs; re-enable -> restarts at digit0, counter 0.
REQ-031 Assert nrst mid-SHOW asynchronously -> outputs blank immediately, all registers 0, no ready pulse after release.
